// File: rtl/link_stats_monitor.sv
// Receive-side packet checker: drains Decoder packets, classifies them against the
// expected LFSR value, keeps saturating statistics and a windowed goodput figure.
module link_stats_monitor #(
   parameter int N_PKT   = 8,
   parameter int CNT_W   = 40,
   parameter int CLK_HZ  = 50_000_000,
   parameter int WINDOW  = 50_000_000,
   parameter int TIMEOUT = 2000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [N_PKT-1:0] dec_data,
   input  logic             dec_avail,
   input  logic             dec_error,
   output logic             dec_read,
   input  logic [N_PKT-1:0] expected,
   output logic             expected_advance,
   output logic [CNT_W-1:0] good_count,
   output logic [CNT_W-1:0] bad_count,
   output logic [CNT_W-1:0] error_count,
   output logic [CNT_W-1:0] timeout_count,
   output logic [CNT_W-1:0] goodput_bps,
   output logic             goodput_valid
);

   localparam int NUM_W  = CNT_W + 36;
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int BIT_W  = $clog2(NUM_W + 1);
   localparam logic [NUM_W-1:0] SCALE   = NUM_W'(N_PKT) * NUM_W'(CLK_HZ);
   localparam logic [WIN_W:0]   DIVISOR = (WIN_W + 1)'(WINDOW);

   // The divide must finish before the next window closes.
   if (WINDOW <= NUM_W) begin : g_window_check
      $error("link_stats_monitor: WINDOW must exceed CNT_W+36");
   end

   typedef enum logic [1:0] {RX_WAIT, RX_READ, RX_DRAIN} rx_state_t;
   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

   rx_state_t        rx_state;
   div_state_t       div_state;
   logic [IDLE_W-1:0] idle_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [CNT_W-1:0]  win_good;
   logic [WIN_W-1:0]  div_rem;
   logic [NUM_W-1:0]  div_quo;
   logic [BIT_W-1:0]  bit_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   logic pkt_match, is_good, is_bad, is_err, win_end;
   logic [CNT_W-1:0] win_good_next;
   logic [NUM_W-1:0] numerator;

   assign pkt_match     = (dec_data == expected);
   assign is_good       = (rx_state == RX_READ) && !dec_error && pkt_match;
   assign is_bad        = (rx_state == RX_READ) && !dec_error && !pkt_match;
   assign is_err        = (rx_state == RX_READ) && dec_error;
   assign win_end       = (win_cnt == WIN_W'(WINDOW - 1));
   assign win_good_next = is_good ? sat_inc(win_good) : win_good;
   assign numerator     = NUM_W'(win_good_next) * SCALE;

   assign dec_read = (rx_state == RX_READ);
   // NOTE: the LFSR must step in the same cycle the packet is judged, so this is
   // combinational; it is gated by rst/clear because that packet's count is discarded.
   assign expected_advance = is_good && !rst && !clear;

   // One restoring-division step: shift the next numerator bit into the remainder.
   logic [WIN_W:0]   trial;
   logic             take;
   logic [WIN_W-1:0] rem_next;
   logic [NUM_W-1:0] quo_next;
   logic [CNT_W-1:0] quo_sat;

   assign trial    = {div_rem, div_quo[NUM_W-1]};
   assign take     = (trial >= DIVISOR);
   assign rem_next = take ? WIN_W'(trial - DIVISOR) : trial[WIN_W-1:0];
   assign quo_next = {div_quo[NUM_W-2:0], take};
   assign quo_sat  = (|quo_next[NUM_W-1:CNT_W]) ? '1 : quo_next[CNT_W-1:0];

   // NOTE: all state here uses non-blocking assignments so every register sees
   // the pre-edge value of every other register, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rx_state      <= RX_WAIT;
         idle_cnt      <= '0;
         good_count    <= '0;
         bad_count     <= '0;
         error_count   <= '0;
         timeout_count <= '0;
      end else begin
         case (rx_state)
            RX_WAIT: begin
               if (dec_avail) begin
                  rx_state <= RX_READ;
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                  timeout_count <= sat_inc(timeout_count);
                  idle_cnt      <= '0;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            RX_READ: begin
               rx_state <= RX_DRAIN;
               if (is_good) good_count  <= sat_inc(good_count);
               if (is_bad)  bad_count   <= sat_inc(bad_count);
               if (is_err)  error_count <= sat_inc(error_count);
            end
            RX_DRAIN: begin
               if (!dec_avail) rx_state <= RX_WAIT;
            end
            default: rx_state <= RX_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         div_state     <= DIV_IDLE;
         win_cnt       <= '0;
         win_good      <= '0;
         div_rem       <= '0;
         div_quo       <= '0;
         bit_cnt       <= '0;
         goodput_bps   <= '0;
         goodput_valid <= 1'b0;
      end else begin
         goodput_valid <= 1'b0;
         case (div_state)
            DIV_RUN: begin
               div_rem <= rem_next;
               div_quo <= quo_next;
               bit_cnt <= bit_cnt - BIT_W'(1);
               if (bit_cnt == BIT_W'(1)) begin
                  div_state     <= DIV_DONE;
                  goodput_bps   <= quo_sat;
                  goodput_valid <= 1'b1;
               end
            end
            DIV_DONE: div_state <= DIV_IDLE;
            default:  div_state <= DIV_IDLE;
         endcase

         // Window close launches a fresh divide; it overrides any divider step above.
         if (win_end) begin
            win_cnt   <= '0;
            win_good  <= '0;
            div_state <= DIV_RUN;
            div_rem   <= '0;
            div_quo   <= numerator;
            bit_cnt   <= BIT_W'(NUM_W);
         end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            win_good <= win_good_next;
         end
      end
   end

endmodule

// File: tb/tb_link_stats_monitor.sv
// Scoreboard bench for link_stats_monitor: stimulus pushes expectations from a
// packet/window-level model, a negedge monitor pops them when the DUT responds.
module tb_link_stats_monitor;

   localparam int N_PKT   = 8;
   localparam int CNT_W   = 40;
   localparam int SAT_W   = 4;
   localparam int CLK_HZ  = 1000;
   localparam int WINDOW  = 100;
   localparam int TIMEOUT = 20;
   localparam int NUM_W   = CNT_W + 36;
   localparam int SAT_MAX = 15;

   logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
   logic dec_avail = 1'b0, dec_error = 1'b0;
   logic [N_PKT-1:0] dec_data = '0, expected = '0;

   logic             dec_read, expected_advance, goodput_valid;
   logic [CNT_W-1:0] good_count, bad_count, error_count, timeout_count, goodput_bps;
   logic             s_dec_read, s_expected_advance, s_goodput_valid;
   logic [SAT_W-1:0] s_good_count, s_bad_count, s_error_count, s_timeout_count, s_goodput_bps;

   link_stats_monitor #(.N_PKT(N_PKT), .CNT_W(CNT_W), .CLK_HZ(CLK_HZ),
                        .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .clear(clear), .dec_data(dec_data), .dec_avail(dec_avail),
      .dec_error(dec_error), .dec_read(dec_read), .expected(expected),
      .expected_advance(expected_advance), .good_count(good_count), .bad_count(bad_count),
      .error_count(error_count), .timeout_count(timeout_count), .goodput_bps(goodput_bps),
      .goodput_valid(goodput_valid));

   link_stats_monitor #(.N_PKT(N_PKT), .CNT_W(SAT_W), .CLK_HZ(CLK_HZ),
                        .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut_sat (
      .clk(clk), .rst(rst), .clear(clear), .dec_data(dec_data), .dec_avail(dec_avail),
      .dec_error(dec_error), .dec_read(s_dec_read), .expected(expected),
      .expected_advance(s_expected_advance), .good_count(s_good_count),
      .bad_count(s_bad_count), .error_count(s_error_count),
      .timeout_count(s_timeout_count), .goodput_bps(s_goodput_bps),
      .goodput_valid(s_goodput_valid));

   always #5 clk = ~clk;

   typedef struct { bit adv; int g; int b; int e; } pkt_exp_t;
   typedef struct { longint val; int due; } gp_exp_t;

   int n_cmp = 0, n_fail = 0;
   int cyc = 0;
   pkt_exp_t pq[$];
   gp_exp_t  gq[$];
   int win_goods[int];
   int m_good = 0, m_bad = 0, m_err = 0, tmo_acc = 0, wait_start = 0;

   function automatic longint sat(longint v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   task automatic check(string name, longint act, longint req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Cycle index since the last reset/clear; window closes push the expected goodput.
   always @(posedge clk) begin : window_model
      int k;
      gp_exp_t x;
      if (rst || clear) begin
         cyc = 0;
         gq.delete();
         win_goods.delete();
      end else begin
         if (cyc % WINDOW == WINDOW - 1) begin
            k = cyc / WINDOW;
            x.val = (win_goods.exists(k) ? longint'(win_goods[k]) : 0) * N_PKT * CLK_HZ / WINDOW;
            x.due = cyc + NUM_W + 1;
            gq.push_back(x);
         end
         cyc++;
      end
   end

   logic     chk_pending = 1'b0;
   pkt_exp_t cur;
   gp_exp_t  gcur;

   always @(negedge clk) begin : monitor
      if (chk_pending) begin
         check("good_count", good_count, cur.g);
         check("bad_count", bad_count, cur.b);
         check("error_count", error_count, cur.e);
         check("sat_good_count", s_good_count, sat(cur.g));
         chk_pending = 1'b0;
      end
      if (!rst) begin
         if (dec_read) begin
            if (pq.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL dec_read: got 1 with no packet outstanding, want 0 (cycle %0d)", cyc);
            end else begin
               cur = pq.pop_front();
               check("expected_advance", expected_advance, cur.adv);
               chk_pending = 1'b1;
            end
         end else if (expected_advance) begin
            n_cmp++; n_fail++;
            $display("FAIL expected_advance: got 1 outside a read, want 0 (cycle %0d)", cyc);
         end
         if (goodput_valid) begin
            if (gq.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL goodput_valid: got 1 with no window pending, want 0 (cycle %0d)", cyc);
            end else begin
               gcur = gq.pop_front();
               check("goodput_bps", goodput_bps, gcur.val);
               check("goodput_cycle", cyc, gcur.due);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One packet: `gap` low cycles, then dec_avail held `hold` (>=2) cycles.
   task automatic send(int gap, int hold, logic [N_PKT-1:0] exp_v,
                       logic [N_PKT-1:0] data, bit err, bit do_clear);
      int t, k;
      bit good;
      pkt_exp_t x;
      tick(gap);
      t = cyc;
      tmo_acc += (t - wait_start) / TIMEOUT;
      dec_avail = 1'b1; dec_data = data; expected = exp_v; dec_error = err;
      good = !err && (data == exp_v);
      if (do_clear) begin
         m_good = 0; m_bad = 0; m_err = 0; tmo_acc = 0;
         x.adv = 1'b0;
      end else begin
         if (err) m_err++;
         else if (good) m_good++;
         else m_bad++;
         x.adv = good;
         if (good) begin
            k = (t + 1) / WINDOW;
            win_goods[k] = win_goods.exists(k) ? win_goods[k] + 1 : 1;
         end
      end
      x.g = m_good; x.b = m_bad; x.e = m_err;
      pq.push_back(x);
      if (do_clear) begin
         tick(1);
         clear = 1'b1;
         tick(1);
         clear = 1'b0; dec_avail = 1'b0;
         wait_start = 0;
      end else begin
         tick(hold);
         dec_avail = 1'b0;
         wait_start = t + hold + 1;
      end
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      m_good = 0; m_bad = 0; m_err = 0; tmo_acc = 0; wait_start = 0;
   endtask

   task automatic checkpoint(string tag);
      longint tmo;
      tick(1);
      @(negedge clk);
      tmo = tmo_acc + (cyc - wait_start) / TIMEOUT;
      check({tag, "_timeout"}, timeout_count, tmo);
      check({tag, "_sat_timeout"}, s_timeout_count, sat(tmo));
      check({tag, "_good"}, good_count, m_good);
      check({tag, "_bad"}, bad_count, m_bad);
      check({tag, "_error"}, error_count, m_err);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [N_PKT-1:0] e, d;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_dec_read", dec_read, 0);
      check("rst_expected_advance", expected_advance, 0);
      check("rst_good", good_count, 0);
      check("rst_bad", bad_count, 0);
      check("rst_error", error_count, 0);
      check("rst_timeout", timeout_count, 0);
      check("rst_goodput", goodput_bps, 0);
      check("rst_goodput_valid", goodput_valid, 0);
      while (cyc < 20) @(negedge clk);
      check("timeout_at_20", timeout_count, 1);
      while (cyc < 100) @(negedge clk);
      check("timeout_at_100", timeout_count, 5);

      send(3, 3, 8'hA5, 8'hA5, 1'b0, 1'b0);
      checkpoint("good_pkt");

      clear_pulse();
      send(3, 2, 8'hA5, 8'h3C, 1'b0, 1'b0);
      send(3, 2, 8'hA5, 8'hA5, 1'b1, 1'b0);
      checkpoint("bad_err");

      for (int i = 0; i < 150; i++) begin
         e = N_PKT'($urandom);
         d = ($urandom_range(0, 1) == 1) ? e : N_PKT'($urandom);
         send($urandom_range(1, 45), $urandom_range(2, 4), e, d,
              ($urandom_range(0, 9) == 0), 1'b0);
      end
      checkpoint("random");

      send(4, 2, 8'h5A, 8'h5A, 1'b0, 1'b1);
      @(negedge clk);
      check("clear_collision_dec_read", dec_read, 0);
      check("clear_collision_good", good_count, 0);

      // Four goods in window 0 after the clear: goodput 4*8*1000/100 = 320.
      for (int i = 0; i < 4; i++) send(2, 2, 8'hC3, 8'hC3, 1'b0, 1'b0);
      while (cyc < 190) tick(1);
      checkpoint("goodput");

      for (int i = 0; i < 20; i++) send(2, 2, 8'h11, 8'h11, 1'b0, 1'b0);
      checkpoint("saturation");
      check("sat_good_holds_15", s_good_count, 15);

      tick(200);
      @(negedge clk);
      check("goodput_overdue", (gq.size() > 0 && gq[0].due <= cyc), 0);
      check("packets_outstanding", pq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
